// File: rtl/tv_pkg.sv
// tv_pkg
//   Shared definitions for the test-vector checker slice: the run-state
//   enum and the default parameter constants used by the interface, the
//   vector memory and the checker top.
package tv_pkg;

  localparam int NI_DEF    = 3;
  localparam int NO_DEF    = 1;
  localparam int DEPTH_DEF = 16;
  localparam int EW_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tvState_t;

endpackage

// File: rtl/tv_if.sv
// tv_if
//   Bundles the control, vector-load, device-under-test and result signals
//   of the checker.
//   master : the side that loads vectors, starts runs and hosts the DUT
//            (drives start/num_vectors/wr_*/dut_out, observes results)
//   slave  : the checker itself (drives dut_in and the result outputs)
interface tv_if
  import tv_pkg::*;
#(
  parameter int NI    = NI_DEF,
  parameter int NO    = NO_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int EW    = EW_DEF
) ();

  localparam int AW = $clog2(DEPTH);

  logic                 start;
  logic [AW:0]          num_vectors;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [NI+NO-1:0]     wr_data;
  logic [NI-1:0]        dut_in;
  logic [NO-1:0]        dut_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [EW-1:0]        errors;
  logic                 fail_valid;
  logic [AW-1:0]        fail_idx;

  modport master (
    output start, num_vectors, wr_en, wr_addr, wr_data, dut_out,
    input  dut_in, busy, done, pass, errors, fail_valid, fail_idx
  );

  modport slave (
    input  start, num_vectors, wr_en, wr_addr, wr_data, dut_out,
    output dut_in, busy, done, pass, errors, fail_valid, fail_idx
  );

endinterface

// File: rtl/tv_mem.sv
// tv_mem
//   DEPTH x (NI+NO) vector store, synchronous write, asynchronous read.
//   Each entry is {stimulus[NI-1:0], expected[NO-1:0]}. Contents are never
//   reset. Two read ports: one returns the expected field of the vector
//   being compared, the other the stimulus field of the vector to apply next.
//   Ports:
//     clk         write clock
//     i_wrEn      write strobe (already qualified by the checker)
//     i_wrAddr    write address
//     i_wrData    entry to store
//     i_expAddr   read address for the expected-response field
//     o_expData   expected response at i_expAddr
//     i_stimAddr  read address for the stimulus field
//     o_stimData  stimulus at i_stimAddr
module tv_mem
  import tv_pkg::*;
#(
  parameter int NI    = NI_DEF,
  parameter int NO    = NO_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int W    = NI + NO
) (
  input  logic          clk,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [W-1:0]  i_wrData,
  input  logic [AW-1:0] i_expAddr,
  output logic [NO-1:0] o_expData,
  input  logic [AW-1:0] i_stimAddr,
  output logic [NI-1:0] o_stimData
);

  logic [W-1:0] r_mem [DEPTH];

  // Plain write port; no reset so stored vectors survive a reset.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_expData  = r_mem[i_expAddr][NO-1:0];
  assign o_stimData = r_mem[i_stimAddr][W-1:NO];

endmodule

// File: rtl/tv_checker.sv
// tv_checker
//   Applies stored test vectors to an external combinational device under
//   test, one vector per cycle, and compares its response with the stored
//   expected value. Counts mismatches (saturating) and records the index of
//   the first failing vector.
//   Ports:
//     clk    sole clock, rising edge
//     reset  synchronous, active-high; wins over start and wr_en
//     bus    tv_if.slave: start/num_vectors, vector write port, dut_in/
//            dut_out, and busy/done/pass/errors/fail_valid/fail_idx
module tv_checker
  import tv_pkg::*;
#(
  parameter int NI    = NI_DEF,
  parameter int NO    = NO_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int EW    = EW_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  tv_if.slave  bus
);

  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_N   = (AW+1)'(1);
  localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};

  tvState_t      r_state;
  tvState_t      w_stateNext;
  logic [AW-1:0] r_idx,       w_idxNext;
  logic [AW:0]   r_n,         w_nNext;
  logic [NI-1:0] r_dutIn,     w_dutInNext;
  logic [EW-1:0] r_errors,    w_errorsNext;
  logic          r_failValid, w_failValidNext;
  logic [AW-1:0] r_failIdx,   w_failIdxNext;

  logic          w_idle;
  logic          w_memWe;
  logic [AW-1:0] w_stimAddr;
  logic [NI-1:0] w_stimData;
  logic [NI-1:0] w_firstStim;
  logic [NO-1:0] w_expData;
  logic [AW:0]   w_nClamp;

  assign w_idle  = (r_state != RUN);
  assign w_memWe = bus.wr_en && w_idle && !reset;

  // While running, the stimulus port looks one vector ahead; outside a run
  // it points at vector 0 so a start can load the first stimulus directly.
  assign w_stimAddr = (r_state == RUN) ? r_idx + 1'b1 : '0;

  tv_mem #(
    .NI    (NI),
    .NO    (NO),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk        (clk),
    .i_wrEn     (w_memWe),
    .i_wrAddr   (bus.wr_addr),
    .i_wrData   (bus.wr_data),
    .i_expAddr  (r_idx),
    .o_expData  (w_expData),
    .i_stimAddr (w_stimAddr),
    .o_stimData (w_stimData)
  );

  // A write to address 0 on the start edge has not reached the array yet,
  // so the first stimulus is forwarded straight from the write data.
  assign w_firstStim = (w_memWe && (bus.wr_addr == '0)) ?
                       bus.wr_data[NI+NO-1:NO] : w_stimData;

  assign w_nClamp = (bus.num_vectors > DEPTH_N) ? DEPTH_N : bus.num_vectors;

  // Next-state and next-datapath logic; everything holds by default.
  always_comb begin
    w_stateNext     = r_state;
    w_idxNext       = r_idx;
    w_nNext         = r_n;
    w_dutInNext     = r_dutIn;
    w_errorsNext    = r_errors;
    w_failValidNext = r_failValid;
    w_failIdxNext   = r_failIdx;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_errorsNext    = '0;
          w_failValidNext = 1'b0;
          w_failIdxNext   = '0;
          w_idxNext       = '0;
          w_nNext         = w_nClamp;
          if (w_nClamp == '0) begin
            w_stateNext = DONE;
          end else begin
            w_stateNext = RUN;
            w_dutInNext = w_firstStim;
          end
        end
      end
      RUN: begin
        if (bus.dut_out != w_expData) begin
          if (r_errors != ERR_MAX) begin
            w_errorsNext = r_errors + 1'b1;
          end
          if (!r_failValid) begin
            w_failValidNext = 1'b1;
            w_failIdxNext   = r_idx;
          end
        end
        if ({1'b0, r_idx} == (r_n - ONE_N)) begin
          w_stateNext = DONE;
        end else begin
          w_idxNext   = r_idx + 1'b1;
          w_dutInNext = w_stimData;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_n         <= '0;
      r_dutIn     <= '0;
      r_errors    <= '0;
      r_failValid <= 1'b0;
      r_failIdx   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_idx       <= w_idxNext;
      r_n         <= w_nNext;
      r_dutIn     <= w_dutInNext;
      r_errors    <= w_errorsNext;
      r_failValid <= w_failValidNext;
      r_failIdx   <= w_failIdxNext;
    end
  end

  assign bus.dut_in     = r_dutIn;
  assign bus.busy       = (r_state == RUN);
  assign bus.done       = (r_state == DONE);
  assign bus.pass       = (r_state == DONE) && (r_errors == '0);
  assign bus.errors     = r_errors;
  assign bus.fail_valid = r_failValid;
  assign bus.fail_idx   = r_failIdx;

endmodule
